sd_wb_arb: RTL and testbench

SD_WB_ARB -- requirements
Module: sd_wb_arb

---
 rtl/sd_wb_pkg.sv | 34 +++
 rtl/sd_wb_arb_if.sv | 26 ++
 rtl/sd_rr_arb2.sv | 26 ++
 rtl/sd_wb_arb.sv | 119 +++++++++++
 tb/tb_sd_wb_arb.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_wb_pkg.sv
`default_nettype none
// ============================================================
// sd_wb_pkg : shared state encoding and Wishbone cycle-type codes
// Rev 1.0
// ============================================================
package sd_wb_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // One-hot grant seen on gnt_o; ABORT owns the bus but grants nobody.
  function automatic logic [1:0] state_gnt(input arb_state_e s);
    logic [1:0] g;
    case (s)
      ST_GNT0: g = 2'b01;
      ST_GNT1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_wb_arb_if.sv
`default_nettype none
// ============================================================
// sd_wb_arb_if : one Wishbone B4 bus (master/slave views)
// Rev 1.0
// ============================================================
interface sd_wb_arb_if;
  import sd_wb_pkg::*;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;

  modport master (output cyc, stb, we, adr, dat_w, sel, cti, bte,
                  input  dat_r, ack);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel, cti, bte,
                  output dat_r, ack, err);
endinterface
`default_nettype wire

// File: rtl/sd_rr_arb2.sv
`default_nettype none
// ============================================================
// sd_rr_arb2 : two-way arbitration decision (fixed or round-robin)
// Rev 1.0
// ============================================================
module sd_rr_arb2 #(
  parameter bit PRIO0 = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      // Contention: requester 0 wins outright, or whoever was not served last.
      if (PRIO0 || last_i) gnt_o = 2'b01;
      else                 gnt_o = 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_wb_arb.sv
`default_nettype none
// ============================================================
// sd_wb_arb : two-requester Wishbone arbiter with per-beat ack timeout
// Rev 1.0
// ============================================================
module sd_wb_arb
  import sd_wb_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter bit PRIO0   = 1'b0
) (
  input  logic        clk_50,
  input  logic        reset_n,
  sd_wb_arb_if.slave  r0,
  sd_wb_arb_if.slave  r1,
  sd_wb_arb_if.master wbm,
  output logic [1:0]  gnt_o
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       arb_gnt;
  logic             sel1, granted, g_cyc, g_stb, raw_stb, timeout, abort_cyc;

  sd_rr_arb2 #(.PRIO0(PRIO0)) u_rr_arb2 (
    .req_i  ({r1.cyc, r0.cyc}),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    sel1      = (state_q == ST_GNT1);
    granted   = (state_q == ST_GNT0) || sel1;
    g_cyc     = sel1 ? r1.cyc : r0.cyc;
    g_stb     = sel1 ? r1.stb : r0.stb;
    raw_stb   = granted & g_stb;
    // An ack in the same cycle as expiry completes the beat instead.
    timeout   = raw_stb & ~wbm.ack & (cnt_q == CNT_MAX);
    abort_cyc = last_q ? r1.cyc : r0.cyc;
  end

  always_comb begin
    wbm.cyc   = reset_n & granted & g_cyc & ~timeout;
    wbm.stb   = reset_n & raw_stb & ~timeout;
    wbm.we    = reset_n & granted & ~timeout & (sel1 ? r1.we : r0.we);
    wbm.adr   = '0;
    wbm.dat_w = '0;
    wbm.sel   = '0;
    wbm.cti   = CTI_CLASSIC;
    wbm.bte   = '0;
    if (granted) begin
      wbm.adr   = sel1 ? r1.adr   : r0.adr;
      wbm.dat_w = sel1 ? r1.dat_w : r0.dat_w;
      wbm.sel   = sel1 ? r1.sel   : r0.sel;
      wbm.cti   = sel1 ? r1.cti   : r0.cti;
      wbm.bte   = sel1 ? r1.bte   : r0.bte;
    end
  end

  always_comb begin
    r0.ack   = reset_n & (state_q == ST_GNT0) & wbm.ack;
    r0.err   = reset_n & (state_q == ST_GNT0) & timeout;
    r0.dat_r = (state_q == ST_GNT0) ? wbm.dat_r : '0;
    r1.ack   = reset_n & (state_q == ST_GNT1) & wbm.ack;
    r1.err   = reset_n & (state_q == ST_GNT1) & timeout;
    r1.dat_r = (state_q == ST_GNT1) ? wbm.dat_r : '0;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt[0]) begin
          state_d = ST_GNT0;
          last_d  = 1'b0;
        end else if (arb_gnt[1]) begin
          state_d = ST_GNT1;
          last_d  = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!g_cyc)       state_d = ST_IDLE;
        else if (timeout) state_d = ST_ABORT;
      end
      ST_ABORT: begin
        // last_q still names the requester that was aborted.
        if (!abort_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || wbm.ack) cnt_d = '0;
    else if (raw_stb && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o = state_gnt(state_q);

endmodule
`default_nettype wire

// File: tb/tb_sd_wb_arb.sv
`default_nettype none
// ============================================================
// tb_sd_wb_arb : scoreboard bench for sd_wb_arb (TIMEOUT=8, round-robin)
// Rev 1.0
// ============================================================
module tb_sd_wb_arb;
  import sd_wb_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_C3C3;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } ev_t;

  logic       clk_50  = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] gnt_o;

  always #5 clk_50 = ~clk_50;

  sd_wb_arb_if r0 ();
  sd_wb_arb_if r1 ();
  sd_wb_arb_if wbm ();

  sd_wb_arb #(.TIMEOUT(8), .PRIO0(1'b0)) dut (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .r0      (r0),
    .r1      (r1),
    .wbm     (wbm),
    .gnt_o   (gnt_o)
  );

  int         n_vec = 0;
  int         n_err = 0;
  ev_t        q0[$];
  ev_t        q1[$];
  logic [1:0] qg[$];
  bit         slave_en = 1'b1;
  int         lat = 0;
  logic [1:0] prev_g = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic err, input logic [31:0] dat);
    ev_t e;
    e.err = err;
    e.dat = dat;
    return e;
  endfunction

  task automatic drive(input int id, input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    if (id == 0) begin
      r0.cyc = cyc; r0.stb = cyc; r0.adr = adr; r0.cti = cti;
    end else begin
      r1.cyc = cyc; r1.stb = cyc; r1.adr = adr; r1.cti = cti;
    end
  endtask

  function automatic logic ack_of(input int id);
    return (id == 0) ? r0.ack : r1.ack;
  endfunction

  task automatic wait_ack(input int id, input int bound, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk_50);
      n = k + 1;
      if (ack_of(id) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_wait r%0d: no ack within %0d cycles, required an ack", id, bound);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with cyc already dropped.
  task automatic do_xfer(input int id, input logic [31:0] base, input int beats);
    bit got;
    int n;
    logic [31:0] a;
    for (int i = 0; i < beats; i++) begin
      a = base + 32'(4 * i);
      drive(id, 1'b1, a, (beats == 1) ? CTI_CLASSIC : ((i == beats - 1) ? CTI_END : CTI_INCR));
      if (id == 0) q0.push_back(mk_ev(1'b0, a ^ KEY));
      else         q1.push_back(mk_ev(1'b0, a ^ KEY));
      wait_ack(id, 400, got, n);
      @(posedge clk_50); #1;
      if (!got) break;
    end
    drive(id, 1'b0, 32'h0, CTI_CLASSIC);
  endtask

  task automatic do_reset();
    @(posedge clk_50); #1;
    reset_n = 1'b0;
    drive(0, 1'b0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b0, 32'h0, CTI_CLASSIC);
    repeat (2) @(posedge clk_50);
    #1 reset_n = 1'b1;
  endtask

  task automatic pop_cmp(input int id, input logic err, input logic [31:0] dat);
    ev_t e;
    bit  empty;
    empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_resp r%0d: got err=%0b dat=%h, required no response", id, err, dat);
    end else begin
      e = (id == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("resp_kind r%0d", id), {31'b0, err}, {31'b0, e.err});
      if (!e.err) check($sformatf("rdat r%0d", id), dat, e.dat);
    end
  endtask

  // Slave model: acks after lat wait cycles; lat=0 acks every strobed cycle (bursts).
  initial begin
    int wcnt;
    wcnt      = 0;
    wbm.ack   = 1'b0;
    wbm.dat_r = 32'h0;
    wbm.err   = 1'b0;
    forever begin
      @(posedge clk_50); #2;
      if (slave_en && wbm.cyc === 1'b1 && wbm.stb === 1'b1) begin
        if (wbm.ack && lat != 0) begin
          wbm.ack = 1'b0;
          wcnt    = 0;
        end else if (wcnt >= lat) begin
          wbm.ack   = 1'b1;
          wbm.dat_r = wbm.adr ^ KEY;
        end else begin
          wcnt++;
          wbm.ack = 1'b0;
        end
      end else begin
        wbm.ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Monitor: responses and new grants are popped against the expected queues.
  always @(negedge clk_50) begin
    if (r0.ack === 1'b1 || r0.err === 1'b1) pop_cmp(0, r0.err, r0.dat_r);
    if (r1.ack === 1'b1 || r1.err === 1'b1) pop_cmp(1, r1.err, r1.dat_r);
    if (reset_n && gnt_o != 2'b00 && gnt_o !== prev_g) begin
      check("gnt_idle_gap", {30'b0, prev_g}, 32'h0);
      if (qg.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_gnt: got %b, required none", gnt_o);
      end else begin
        check("gnt_order", {30'b0, gnt_o}, {30'b0, qg.pop_front()});
      end
    end
    prev_g <= gnt_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n;
    int k;
    r0.we = 1'b0; r0.dat_w = 32'h0; r0.sel = 4'hF; r0.bte = 2'b00;
    r1.we = 1'b0; r1.dat_w = 32'h0; r1.sel = 4'hF; r1.bte = 2'b00;
    drive(0, 1'b0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b0, 32'h0, CTI_CLASSIC);
    reset_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_50);
    @(negedge clk_50);
    check("rst_gnt", {30'b0, gnt_o}, 32'h0);
    check("rst_wbm_cyc", {31'b0, wbm.cyc}, 32'h0);
    check("rst_wbm_stb", {31'b0, wbm.stb}, 32'h0);
    check("rst_wbm_we", {31'b0, wbm.we}, 32'h0);
    check("rst_acks", {28'b0, r0.ack, r0.err, r1.ack, r1.err}, 32'h0);
    @(posedge clk_50); #1 reset_n = 1'b1;
    @(negedge clk_50);
    check("post_rst_wbm_cyc", {31'b0, wbm.cyc}, 32'h0);

    // Single read from r0, ack on the 3rd granted cycle
    lat = 2;
    qg.push_back(2'b01);
    @(posedge clk_50); #1;
    drive(0, 1'b1, 32'h100, CTI_CLASSIC);
    q0.push_back(mk_ev(1'b0, 32'h100 ^ KEY));
    @(negedge clk_50);
    check("arb_latency_gnt", {30'b0, gnt_o}, 32'h0);
    @(negedge clk_50);
    check("gnt_r0", {30'b0, gnt_o}, 32'h1);
    check("wbm_cyc_follow", {31'b0, wbm.cyc}, 32'h1);
    check("wbm_adr_follow", wbm.adr, 32'h100);
    check("wbm_sel_follow", {28'b0, wbm.sel}, 32'hF);
    wait_ack(0, 10, got, n);
    check("ack_cycle", n, 2);
    check("r1_idle_outputs", {r1.ack, r1.err, r1.dat_r[29:0]}, 32'h0);
    @(posedge clk_50); #1;
    drive(0, 1'b0, 32'h0, CTI_CLASSIC);
    @(negedge clk_50);
    @(negedge clk_50);
    check("idle_after_drop", {30'b0, gnt_o}, 32'h0);

    // Round-robin alternation, r0 first after reset
    lat = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      qg.push_back(2'b01);
      qg.push_back(2'b10);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          do_xfer(0, 32'h200 + 32'(16 * i), 1);
          @(posedge clk_50); #1;
        end
      end
      begin
        for (int j = 0; j < 3; j++) begin
          do_xfer(1, 32'h300 + 32'(16 * j), 1);
          @(posedge clk_50); #1;
        end
      end
    join

    // 128-beat burst on r1 holds the grant while r0 waits
    qg.push_back(2'b10);
    qg.push_back(2'b01);
    fork
      do_xfer(1, 32'h1000, 128);
      begin
        repeat (20) @(posedge clk_50);
        #1 do_xfer(0, 32'h400, 1);
      end
    join

    // Ack timeout on r0, then ABORT holds off a waiting r1
    @(posedge clk_50); #1;
    slave_en = 1'b0;
    qg.push_back(2'b01);
    q0.push_back(mk_ev(1'b1, 32'h0));
    drive(0, 1'b1, 32'h500, CTI_CLASSIC);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50);
      if (wbm.stb === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("to_stb_seen", {31'b0, got}, 32'h1);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50);
      k++;
      if (r0.err === 1'b1) break;
    end
    check("to_err_cycle", k, 8);
    check("to_wbm_cyc_low", {30'b0, wbm.cyc, wbm.stb}, 32'h0);
    @(posedge clk_50); #1;
    drive(1, 1'b1, 32'h600, CTI_CLASSIC);
    slave_en = 1'b1;
    qg.push_back(2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50);
      check("abort_gnt", {30'b0, gnt_o}, 32'h0);
      check("abort_wbm_cyc", {31'b0, wbm.cyc}, 32'h0);
    end
    @(posedge clk_50); #1;
    drive(0, 1'b0, 32'h0, CTI_CLASSIC);
    do_xfer(1, 32'h600, 1);

    // Reset during beat 5 of an r0 burst
    @(posedge clk_50); #1;
    qg.push_back(2'b01);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 32'h2000 + 32'(4 * i), CTI_INCR);
      q0.push_back(mk_ev(1'b0, (32'h2000 + 32'(4 * i)) ^ KEY));
      wait_ack(0, 20, got, n);
      @(posedge clk_50); #1;
    end
    drive(0, 1'b1, 32'h2010, CTI_INCR);
    reset_n = 1'b0;
    @(negedge clk_50);
    check("rst_mid_outputs", {29'b0, r0.ack, r0.err, wbm.cyc}, 32'h0);
    @(posedge clk_50); #1;
    drive(0, 1'b0, 32'h0, CTI_CLASSIC);
    @(negedge clk_50);
    check("rst_mid_gnt", {30'b0, gnt_o}, 32'h0);
    check("rst_mid_wbm_cyc", {31'b0, wbm.cyc}, 32'h0);
    @(posedge clk_50); #1 reset_n = 1'b1;

    // After reset, simultaneous requests go to r0 first
    qg.push_back(2'b01);
    qg.push_back(2'b10);
    @(posedge clk_50); #1;
    fork
      do_xfer(0, 32'h700, 1);
      do_xfer(1, 32'h800, 1);
    join

    repeat (5) @(posedge clk_50);
    @(negedge clk_50);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("gnt_q_drained", qg.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
